// File: rtl/u_processor_pc_pkg.sv
// Shared definitions for u_processor_pc: opcodes, FSM states and the
// bit positions of the 16-bit instruction fields.
package proc_pkg;

  localparam logic [3:0] OP_NOP   = 4'h0;
  localparam logic [3:0] OP_LDI   = 4'h1;
  localparam logic [3:0] OP_LOAD  = 4'h2;
  localparam logic [3:0] OP_STORE = 4'h3;
  localparam logic [3:0] OP_ADD   = 4'h4;
  localparam logic [3:0] OP_SUB   = 4'h5;
  localparam logic [3:0] OP_MOVR  = 4'h6;
  localparam logic [3:0] OP_MOVA  = 4'h7;
  localparam logic [3:0] OP_JMP   = 4'h8;
  localparam logic [3:0] OP_JZ    = 4'h9;
  localparam logic [3:0] OP_HALT  = 4'hF;

  localparam int OP_LSB  = 12;
  localparam int RD_LSB  = 8;
  localparam int RS_LSB  = 4;
  localparam int IMM_LSB = 0;

  typedef enum logic [1:0] {
    ST_FETCH,
    ST_EXEC,
    ST_MEM,
    ST_HALTED
  } state_e;

  function automatic logic [3:0] instr_field(input logic [15:0] instr, input int lsb);
    return instr[lsb +: 4];
  endfunction

endpackage

// File: rtl/u_processor_pc_if.sv
// Shared instruction/data memory port with a req/ack handshake; the processor
// is the master, the cache/memory subsystem the slave.
interface u_processor_pc_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16
);

  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ack;

  modport master (
    output mem_req,
    output mem_we,
    output mem_addr,
    output mem_wdata,
    input  mem_rdata,
    input  mem_ack
  );

  modport slave (
    input  mem_req,
    input  mem_we,
    input  mem_addr,
    input  mem_wdata,
    output mem_rdata,
    output mem_ack
  );

endinterface

// File: rtl/u_processor_pc_regfile.sv
// General-purpose register file: R0 reads zero, indices at or above NUM_GPR
// read zero and ignore writes, so only NUM_GPR-1 registers hold state.
module proc_regfile #(
  parameter int DATA_W  = 16,
  parameter int NUM_GPR = 11
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              we_i,
  input  logic [3:0]        waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [3:0]        raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] regs [16];

  assign regs[0] = '0;

  for (genvar g = 1; g < 16; g++) begin : g_reg
    if (g < NUM_GPR) begin : g_real
      logic [DATA_W-1:0] reg_q;

      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
          reg_q <= '0;
        end else if (we_i && (waddr_i == 4'(g))) begin
          reg_q <= wdata_i;
        end
      end

      assign regs[g] = reg_q;
    end else begin : g_absent
      assign regs[g] = '0;
    end
  end

  assign rdata_o = regs[raddr_i];

endmodule

// File: rtl/u_processor_pc.sv
// Parametrised multicycle accumulator processor with a fetch/exec/mem FSM on a
// single req/ack memory port. Define U_PROCESSOR_PERF_CNT_EN for perf counters.
module u_processor_pc
  import proc_pkg::*;
#(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 16,
  parameter int NUM_GPR  = 11,
  parameter int RESET_PC = 1
) (
  input  logic                clk_100,
  input  logic                rst_n,
  u_processor_pc_if.master    mem,
  output logic [15:0]         instruction,
  output logic [DATA_W-1:0]   acc,
  output logic                z,
  output logic                finished,
  output logic [31:0]         cycle_cnt,
  output logic [31:0]         retired_cnt
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [DATA_W-1:0] acc_q, acc_d;
  logic              z_q, z_d;
  logic [15:0]       ir_q, ir_d;

  logic [3:0]        op;
  logic [7:0]        imm8;
  logic [DATA_W-1:0] rs_val;
  logic              rf_we;
  logic              upd_z;
  logic              retire;
  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;

  assign op   = instr_field(ir_q, OP_LSB);
  assign imm8 = ir_q[IMM_LSB +: 8];

  proc_regfile #(
    .DATA_W  (DATA_W),
    .NUM_GPR (NUM_GPR)
  ) u_regfile (
    .clk_i   (clk_100),
    .rst_ni  (rst_n),
    .we_i    (rf_we),
    .waddr_i (instr_field(ir_q, RD_LSB)),
    .wdata_i (acc_q),
    .raddr_i (instr_field(ir_q, RS_LSB)),
    .rdata_o (rs_val)
  );

  always_ff @(posedge clk_100 or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_FETCH;
      pc_q    <= ADDR_W'(RESET_PC);
      acc_q   <= '0;
      z_q     <= 1'b0;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      acc_q   <= acc_d;
      z_q     <= z_d;
      ir_q    <= ir_d;
    end
  end

  // Request outputs depend only on state and registered operands, so they stay
  // frozen for the whole wait on mem_ack.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    acc_d    = acc_q;
    z_d      = z_q;
    ir_d     = ir_q;
    rf_we    = 1'b0;
    upd_z    = 1'b0;
    retire   = 1'b0;
    req      = 1'b0;
    we       = 1'b0;
    addr     = pc_q;
    wdata    = '0;
    finished = 1'b0;

    unique case (state_q)
      ST_FETCH: begin
        req = 1'b1;
        if (mem.mem_ack) begin
          ir_d    = mem.mem_rdata[15:0];
          pc_d    = pc_q + ADDR_W'(1);
          state_d = ST_EXEC;
        end
      end

      ST_EXEC: begin
        state_d = ST_FETCH;
        retire  = 1'b1;
        case (op)
          OP_NOP: ;
          OP_LDI: begin
            acc_d = DATA_W'(imm8);
            upd_z = 1'b1;
          end
          OP_LOAD, OP_STORE: begin
            state_d = ST_MEM;
            retire  = 1'b0;
          end
          OP_ADD: begin
            acc_d = acc_q + rs_val;
            upd_z = 1'b1;
          end
          OP_SUB: begin
            acc_d = acc_q - rs_val;
            upd_z = 1'b1;
          end
          OP_MOVR: rf_we = 1'b1;
          OP_MOVA: begin
            acc_d = rs_val;
            upd_z = 1'b1;
          end
          OP_JMP: pc_d = ADDR_W'(imm8);
          OP_JZ: begin
            if (z_q) begin
              pc_d = ADDR_W'(imm8);
            end
          end
          OP_HALT: state_d = ST_HALTED;
          default: ;
        endcase
      end

      ST_MEM: begin
        req  = 1'b1;
        we   = (op == OP_STORE);
        addr = rs_val[ADDR_W-1:0];
        if (op == OP_STORE) begin
          wdata = acc_q;
        end
        if (mem.mem_ack) begin
          if (op == OP_LOAD) begin
            acc_d = mem.mem_rdata;
            upd_z = 1'b1;
          end
          state_d = ST_FETCH;
          retire  = 1'b1;
        end
      end

      ST_HALTED: finished = 1'b1;

      default: state_d = ST_FETCH;
    endcase

    if (upd_z) begin
      z_d = (acc_d == '0);
    end
  end

  // Gating with rst_n abandons an in-flight access the moment reset asserts.
  assign mem.mem_req   = req & rst_n;
  assign mem.mem_we    = we & rst_n;
  assign mem.mem_addr  = addr;
  assign mem.mem_wdata = wdata;

  assign instruction = ir_q;
  assign acc         = acc_q;
  assign z           = z_q;

`ifdef U_PROCESSOR_PERF_CNT_EN
  logic [31:0] cycle_cnt_q;
  logic [31:0] retired_cnt_q;

  // Both counters saturate rather than wrap so long runs never read as short ones.
  always_ff @(posedge clk_100 or negedge rst_n) begin
    if (!rst_n) begin
      cycle_cnt_q   <= '0;
      retired_cnt_q <= '0;
    end else begin
      if ((state_q != ST_HALTED) && (cycle_cnt_q != 32'hFFFF_FFFF)) begin
        cycle_cnt_q <= cycle_cnt_q + 32'd1;
      end
      if (retire && (retired_cnt_q != 32'hFFFF_FFFF)) begin
        retired_cnt_q <= retired_cnt_q + 32'd1;
      end
    end
  end

  assign cycle_cnt   = cycle_cnt_q;
  assign retired_cnt = retired_cnt_q;
`else
  logic unused_retire;
  assign unused_retire = retire;
  assign cycle_cnt     = '0;
  assign retired_cnt   = '0;
`endif

endmodule
